// File: rtl/wb_queue.sv
// Register-file write queue: a circular FIFO of pending ALU/load writes that drains one entry per cycle.
// Define WBQ_FWD_EN to enable combinational forwarding of queued data to the two register-file read ports.
module wb_queue #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       alu_valid,
  output logic                       alu_ready,
  input  logic [4:0]                 alu_addr,
  input  logic [31:0]                alu_data,
  input  logic                       mem_valid,
  output logic                       mem_ready,
  input  logic [4:0]                 mem_addr,
  input  logic [31:0]                mem_data,
  output logic                       write,
  output logic [4:0]                 writeaddress,
  output logic [31:0]                dinreg,
  input  logic [4:0]                 addreg1,
  input  logic [4:0]                 addreg2,
  output logic                       fwd1_hit,
  output logic [31:0]                fwd1_data,
  output logic                       fwd2_hit,
  output logic [31:0]                fwd2_data,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } entry_t;

  entry_t          store [DEPTH];
  logic [AW-1:0]   head;
  logic [AW-1:0]   tail;
  logic [AW-1:0]   mem_slot;
  logic [CW-1:0]   count;
  logic [CW-1:0]   free;
  logic [CW-1:0]   pushes;
  logic            pop;
  logic            alu_acc;
  logic            mem_acc;

  // The register file always accepts, so any non-empty queue retires its head this cycle.
  assign pop  = (count != '0);
  assign free = CW'(DEPTH) - count + CW'(pop);

  always_comb begin
    alu_ready = 1'b0;
    mem_ready = 1'b0;
    if (!rst) begin
      if (free >= CW'(2)) begin
        alu_ready = 1'b1;
        mem_ready = 1'b1;
      end else if (free == CW'(1)) begin
        // Load data has priority for the last slot.
        mem_ready = 1'b1;
        alu_ready = !mem_valid;
      end
    end
  end

  assign alu_acc  = alu_valid && alu_ready;
  assign mem_acc  = mem_valid && mem_ready;
  assign pushes   = CW'(alu_acc) + CW'(mem_acc);
  // On a dual acceptance the ALU entry is older, so the load lands one slot behind it.
  assign mem_slot = tail + AW'(alu_acc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      head  <= head + AW'(pop);
      tail  <= tail + pushes[AW-1:0];
      count <= count + pushes - CW'(pop);
    end
  end

  // NOTE: storage is deliberately not reset; count gates every read, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (alu_acc) store[tail]     <= '{addr: alu_addr, data: alu_data};
    if (mem_acc) store[mem_slot] <= '{addr: mem_addr, data: mem_data};
  end

  assign write        = pop;
  assign writeaddress = pop ? store[head].addr : '0;
  assign dinreg       = pop ? store[head].data : '0;
  assign occupancy    = count;

`ifdef WBQ_FWD_EN
  logic [AW-1:0] idx;

  // Walk oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    fwd1_hit  = 1'b0;
    fwd1_data = '0;
    fwd2_hit  = 1'b0;
    fwd2_data = '0;
    idx       = head;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + AW'(k);
      if (CW'(k) < count) begin
        if (store[idx].addr == addreg1) begin
          fwd1_hit  = 1'b1;
          fwd1_data = store[idx].data;
        end
        if (store[idx].addr == addreg2) begin
          fwd2_hit  = 1'b1;
          fwd2_data = store[idx].data;
        end
      end
    end
  end
`else
  logic unused_addreg;
  assign unused_addreg = ^{addreg1, addreg2};
  assign fwd1_hit  = 1'b0;
  assign fwd1_data = '0;
  assign fwd2_hit  = 1'b0;
  assign fwd2_data = '0;
`endif

endmodule
